// File: rtl/passcode_lock_if.sv
// Button-side inputs and display-side status of the passcode lock.
// Parameters must match those of the controller it is bound to.
interface passcode_lock_if #(
   parameter int DIGITS    = 4,
   parameter int DIGIT_W   = 4,
   parameter int MAX_FAILS = 3
);
   localparam int CW    = DIGITS * DIGIT_W;
   localparam int CNT_W = $clog2(DIGITS + 1);
   localparam int FC_W  = $clog2(MAX_FAILS + 1);

   logic [DIGIT_W-1:0] hex_in;
   logic               enter;
   logic               change;
   logic               set;
   logic [CW-1:0]      current_password;
   logic [CW-1:0]      entry_buf;
   logic [CNT_W-1:0]   digit_count;
   logic [1:0]         state;
   logic               unlocked;
   logic               fail;
   logic [FC_W-1:0]    fail_count;

   modport master (
      output hex_in, enter, change, set,
      input  current_password, entry_buf, digit_count,
      input  state, unlocked, fail, fail_count
   );

   modport slave (
      input  hex_in, enter, change, set,
      output current_password, entry_buf, digit_count,
      output state, unlocked, fail, fail_count
   );
endinterface

// File: rtl/passcode_lock_ctrl.sv
// Passcode lock: digit entry, code compare, change-code flow
// and timed lockout after repeated bad attempts.
module passcode_lock_ctrl #(
   parameter int DIGITS         = 4,
   parameter int DIGIT_W        = 4,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'hFFFF
) (
   input  logic clk,
   input  logic reset,
   passcode_lock_if.slave bus
);
   localparam int CW    = DIGITS * DIGIT_W;
   localparam int CNT_W = $clog2(DIGITS + 1);
   localparam int FC_W  = $clog2(MAX_FAILS + 1);
   localparam int TW    = $clog2(LOCKOUT_CYCLES);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);
   localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAILS);
   localparam logic [TW-1:0]    T_LOAD   = TW'(LOCKOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      LOCKED   = 2'b00,
      UNLOCKED = 2'b01,
      SET_NEW  = 2'b10,
      LOCKOUT  = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    buf_q, buf_d;
   logic [CW-1:0]    pw_q, pw_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [FC_W-1:0]  fcnt_q, fcnt_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             fail_q, fail_d;
   logic             unl_q, unl_d;
   logic             enter_q, change_q, set_q;

   logic             enter_rise, change_rise, set_rise;
   logic [CW-1:0]    buf_shift;
   logic [FC_W-1:0]  fcnt_inc;

   assign enter_rise  = bus.enter & ~enter_q;
   assign change_rise = bus.change & ~change_q;
   assign set_rise    = bus.set & ~set_q;
   assign buf_shift   = CW'({buf_q, bus.hex_in});
   assign fcnt_inc    = fcnt_q + 1'b1;

   // Next-state: lockout overrides all buttons, then change > set > enter.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      pw_d    = pw_q;
      cnt_d   = cnt_q;
      fcnt_d  = fcnt_q;
      timer_d = timer_q;
      fail_d  = 1'b0;
      if (state_q == LOCKOUT) begin
         if (timer_q == '0) begin
            state_d = LOCKED;
            fcnt_d  = '0;
            buf_d   = '0;
            cnt_d   = '0;
         end else begin
            timer_d = timer_q - 1'b1;
         end
      end else if (change_rise) begin
         buf_d = '0;
         cnt_d = '0;
         if (state_q != LOCKED) state_d = SET_NEW;
      end else if (set_rise) begin
         buf_d = '0;
         cnt_d = '0;
         if (state_q == UNLOCKED) begin
            state_d = LOCKED;
         end else if (state_q == SET_NEW) begin
            if (cnt_q == CNT_FULL) begin
               pw_d    = buf_q;
               state_d = LOCKED;
            end else begin
               state_d = UNLOCKED;
            end
         end
      end else if (enter_rise && state_q != UNLOCKED
                   && cnt_q < CNT_FULL) begin
         if (state_q == LOCKED && cnt_q == CNT_LAST) begin
            buf_d = '0;
            cnt_d = '0;
            if (buf_shift == pw_q) begin
               state_d = UNLOCKED;
               fcnt_d  = '0;
            end else begin
               fail_d = 1'b1;
               fcnt_d = fcnt_inc;
               if (fcnt_inc == FC_MAX) begin
                  state_d = LOCKOUT;
                  timer_d = T_LOAD;
               end
            end
         end else begin
            buf_d = buf_shift;
            cnt_d = cnt_q + 1'b1;
         end
      end
      unl_d = (state_d == UNLOCKED) || (state_d == SET_NEW);
   end

   // State and datapath registers; edge detectors reset high so
   // a button held through reset does not count as a press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= LOCKED;
         buf_q    <= '0;
         pw_q     <= DEFAULT_CODE;
         cnt_q    <= '0;
         fcnt_q   <= '0;
         timer_q  <= '0;
         fail_q   <= 1'b0;
         unl_q    <= 1'b0;
         enter_q  <= 1'b1;
         change_q <= 1'b1;
         set_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         buf_q    <= buf_d;
         pw_q     <= pw_d;
         cnt_q    <= cnt_d;
         fcnt_q   <= fcnt_d;
         timer_q  <= timer_d;
         fail_q   <= fail_d;
         unl_q    <= unl_d;
         enter_q  <= bus.enter;
         change_q <= bus.change;
         set_q    <= bus.set;
      end
   end

   assign bus.current_password = pw_q;
   assign bus.entry_buf        = buf_q;
   assign bus.digit_count      = cnt_q;
   assign bus.state            = state_q;
   assign bus.unlocked         = unl_q;
   assign bus.fail             = fail_q;
   assign bus.fail_count       = fcnt_q;
endmodule

// File: tb/tb_passcode_lock_ctrl.sv
// Directed bench for passcode_lock_ctrl with a 16-cycle lockout.
// Expected values are hand-derived from the lock behaviour.
module tb_passcode_lock_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   fail_seen = 0;
   int   lock_seen = 0;

   passcode_lock_if #(.DIGITS(4), .DIGIT_W(4), .MAX_FAILS(3)) bus ();

   passcode_lock_ctrl #(
      .DIGITS(4), .DIGIT_W(4), .MAX_FAILS(3),
      .LOCKOUT_CYCLES(16), .DEFAULT_CODE(16'hFFFF)
   ) dut (
      .clk(clk),
      .reset(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Count fail-high cycles and lockout cycles, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.fail) fail_seen = fail_seen + 1;
      if (bus.state == 2'b11) lock_seen = lock_seen + 1;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic press_digit(input logic [3:0] d);
      @(negedge clk);
      bus.hex_in = d;
      bus.enter  = 1'b1;
      @(negedge clk);
      bus.enter  = 1'b0;
   endtask

   task automatic enter_code(input logic [15:0] code);
      for (int i = 3; i >= 0; i--) begin
         logic [15:0] c;
         c = code >> (4 * i);
         press_digit(c[3:0]);
      end
      @(negedge clk);
   endtask

   task automatic press_change();
      @(negedge clk);
      bus.change = 1'b1;
      @(negedge clk);
      bus.change = 1'b0;
      @(negedge clk);
   endtask

   task automatic press_set();
      @(negedge clk);
      bus.set = 1'b1;
      @(negedge clk);
      bus.set = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int n;
      bus.hex_in = '0;
      bus.enter  = 1'b0;
      bus.change = 1'b0;
      bus.set    = 1'b0;
      rst_n      = 1'b0;
      do_reset();

      check("rst_state", 32'(bus.state), 32'h0);
      check("rst_pw", 32'(bus.current_password), 32'hFFFF);
      check("rst_buf", 32'(bus.entry_buf), 32'h0);
      check("rst_cnt", 32'(bus.digit_count), 32'h0);
      check("rst_fcnt", 32'(bus.fail_count), 32'h0);
      check("rst_unl", 32'(bus.unlocked), 32'h0);

      // T1
      fail_seen = 0;
      press_digit(4'hF);
      press_digit(4'hF);
      check("t1_partial_buf", 32'(bus.entry_buf), 32'hFF);
      check("t1_partial_cnt", 32'(bus.digit_count), 32'h2);
      press_digit(4'hF);
      press_digit(4'hF);
      @(negedge clk);
      check("t1_state", 32'(bus.state), 32'h1);
      check("t1_unl", 32'(bus.unlocked), 32'h1);
      check("t1_nofail", 32'(fail_seen), 32'h0);
      check("t1_fcnt", 32'(bus.fail_count), 32'h0);

      // T2
      press_change();
      check("t2_setnew", 32'(bus.state), 32'h2);
      check("t2_setnew_unl", 32'(bus.unlocked), 32'h1);
      enter_code(16'hAAAA);
      check("t2_buf", 32'(bus.entry_buf), 32'hAAAA);
      check("t2_cnt", 32'(bus.digit_count), 32'h4);
      press_set();
      check("t2_pw", 32'(bus.current_password), 32'hAAAA);
      check("t2_locked", 32'(bus.state), 32'h0);
      enter_code(16'hAAAA);
      check("t2_unlock_new", 32'(bus.state), 32'h1);
      press_set();
      check("t2_relock", 32'(bus.state), 32'h0);
      fail_seen = 0;
      enter_code(16'hFFFF);
      check("t2_fail_pulse", 32'(fail_seen), 32'h1);
      check("t2_fcnt", 32'(bus.fail_count), 32'h1);
      check("t2_still_locked", 32'(bus.state), 32'h0);
      check("t2_buf_clr", 32'(bus.entry_buf), 32'h0);

      // T3
      do_reset();
      fail_seen = 0;
      lock_seen = 0;
      enter_code(16'h0000);
      enter_code(16'h0000);
      check("t3_fcnt2", 32'(bus.fail_count), 32'h2);
      enter_code(16'h0000);
      check("t3_fails", 32'(fail_seen), 32'h3);
      check("t3_lockout", 32'(bus.state), 32'h3);
      check("t3_fcnt3", 32'(bus.fail_count), 32'h3);
      press_digit(4'h1);
      check("t3_ignored", 32'(bus.digit_count), 32'h0);
      n = 0;
      while (bus.state == 2'b11 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("t3_exit_timeout", 32'(n < 40), 32'h1);
      check("t3_duration", 32'(lock_seen), 32'd16);
      check("t3_state", 32'(bus.state), 32'h0);
      check("t3_fcnt_clr", 32'(bus.fail_count), 32'h0);
      enter_code(16'hFFFF);
      check("t3_unlock", 32'(bus.state), 32'h1);

      // T4
      press_change();
      press_digit(4'h5);
      press_digit(4'h5);
      check("t4_cnt2", 32'(bus.digit_count), 32'h2);
      press_set();
      check("t4_abort_state", 32'(bus.state), 32'h1);
      check("t4_abort_pw", 32'(bus.current_password), 32'hFFFF);
      check("t4_abort_buf", 32'(bus.entry_buf), 32'h0);
      press_change();
      for (int i = 0; i < 6; i++) press_digit(4'h5);
      check("t4_sat_cnt", 32'(bus.digit_count), 32'h4);
      check("t4_sat_buf", 32'(bus.entry_buf), 32'h5555);
      press_set();
      check("t4_pw", 32'(bus.current_password), 32'h5555);
      check("t4_state", 32'(bus.state), 32'h0);

      // T5
      do_reset();
      enter_code(16'hFFFF);
      press_change();
      enter_code(16'h1234);
      @(negedge clk);
      bus.hex_in = 4'h9;
      bus.enter  = 1'b1;
      bus.set    = 1'b1;
      @(negedge clk);
      bus.enter  = 1'b0;
      bus.set    = 1'b0;
      @(negedge clk);
      check("t5_pw", 32'(bus.current_password), 32'h1234);
      check("t5_state", 32'(bus.state), 32'h0);
      check("t5_cnt", 32'(bus.digit_count), 32'h0);
      check("t5_buf", 32'(bus.entry_buf), 32'h0);
      bus.change = 1'b1;
      bus.enter  = 1'b1;
      bus.hex_in = 4'h3;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("t5_held_state", 32'(bus.state), 32'h0);
      check("t5_held_cnt", 32'(bus.digit_count), 32'h0);
      bus.change = 1'b0;
      bus.enter  = 1'b0;
      @(negedge clk);

      // T6
      enter_code(16'hFFFF);
      press_change();
      press_digit(4'h7);
      press_digit(4'h7);
      check("t6_pre_state", 32'(bus.state), 32'h2);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_state", 32'(bus.state), 32'h0);
      check("t6_pw", 32'(bus.current_password), 32'hFFFF);
      check("t6_buf", 32'(bus.entry_buf), 32'h0);
      check("t6_unl", 32'(bus.unlocked), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
